ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the St.PU five-stage pipeline. It sits between the decode stage and the memory stage.
- It latches the decoded operation and operands into an internal ID/EX register, then evaluates the logic, shift and arithmetic result.
- It drives a combinational forwarding bus (ex_wreg_o / ex_wd_o / ex_wdata_o) back to decode, and registers the result into the EX/MEM register for the memory stage.

Parameters:
- none. Widths come from the shared defines: RegBus=32, RegAddrBus=5, AluOpBus=8, AluSelBus=3.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1).
- stall_i  in  1  hold the instruction currently in EX.
- flush_i  in  1  kill the instruction currently in EX.
- aluop_i  in  8  operation code from decode (EXE_*_OP).
- alusel_i  in  3  result class from decode (EXE_RES_*).
- reg1_i  in  32  operand 1 (register value or immediate/shamt).
- reg2_i  in  32  operand 2.
- wd_i  in  5  destination register address.
- wreg_i  in  1  destination write enable.
- ex_wreg_o  out  1  forwarding: instruction now in EX writes a register.
- ex_wd_o  out  5  forwarding: destination address.
- ex_wdata_o  out  32  forwarding: result.
- mem_wreg_o  out  1  EX/MEM register: write enable.
- mem_wd_o  out  5  EX/MEM register: destination address.
- mem_wdata_o  out  32  EX/MEM register: result.
- ovf_o  out  1  EX/MEM register: previous EX instruction raised signed overflow.

Behaviour:

ID/EX register S = {aluop, alusel, reg1, reg2, wd, wreg}, updated on rising clk. Priority is rst > flush_i > stall_i > load.
- rst or flush_i: S is cleared to aluop=EXE_NOP_OP, alusel=EXE_RES_NOP, reg1=reg2=ZeroWord, wd=NOPRegAddr, wreg=0.
- stall_i=1: S holds its value.
- otherwise: S loads the *_i inputs.

Result is computed combinationally from S:
- EXE_RES_LOGIC: OR, AND, XOR, NOR of reg1 and reg2.
- EXE_RES_SHIFT: reg2 shifted by reg1[4:0].
  - SLL: logical left.
  - SRL: logical right, zero fill.
  - SRA: arithmetic right, sign fill from reg2[31].
  - Shift by 0 returns reg2 unchanged.
- EXE_RES_ARITHMETIC:
  - ADD/ADDU: reg1+reg2, mod 2^32.
  - SUB/SUBU: reg1-reg2, mod 2^32.
  - SLT: 1 if signed reg1 < reg2, else 0.
  - SLTU: 1 if unsigned reg1 < reg2, else 0.
- EXE_RES_NOP, or an aluop not valid for the selected class: result = ZeroWord.

Overflow:
- ADD and SUB only: ovf = operand signs are compatible for overflow and the result sign differs. Overflow is signed two's-complement overflow.
- ADDU and SUBU never flag overflow.

Forwarding bus (combinational, no register):
- ex_wd_o = S.wd.
- ex_wdata_o = result.
- ex_wreg_o = S.wreg AND NOT ovf.
- During reset, and in the cycle after rst/flush, the bus reads 0 / NOPRegAddr / ZeroWord.

EX/MEM register, updated on rising clk:
- rst or flush_i: mem_wreg_o=0, mem_wd_o=NOPRegAddr, mem_wdata_o=ZeroWord, ovf_o=0.
- stall_i=1: a bubble is loaded (same values as reset). This prevents a held instruction from writing twice.
- otherwise: mem_* outputs load the ex_* bus values, and ovf_o loads ovf.

Latency:
- Inputs presented in cycle N appear on ex_* in cycle N+1.
- They appear on mem_* in cycle N+2, unless a stall delays them.

Boundary conditions:
- wd=0 is passed through unchanged. Discarding writes to register 0 is the regfile's job.
- flush_i and stall_i asserted together: flush wins.
- rst asserted mid-stall: all state clears and the held instruction is lost.
- A held instruction reaches MEM exactly once: on the first cycle with stall_i=0 after the hold.

Test Plan:
1. Logic OR: load OR, reg1=0x0000F0F0, reg2=0x12340000, wd=5, wreg=1 -> next cycle ex_wdata_o=0x1234F0F0, ex_wd_o=5, ex_wreg_o=1; cycle after, mem_wdata_o=0x1234F0F0, mem_wreg_o=1.
2. Shifts: reg1=4, reg2=0x80000010 -> SRA gives 0xF8000001, SRL gives 0x08000001, SLL gives 0x00000100. Also reg1=0 with SRA returns 0x80000010.
3. Overflow on ADD: ADD 0x7FFFFFFF+0x00000001 -> ex_wreg_o=0; next cycle ovf_o=1, mem_wreg_o=0. ADDU with the same operands gives 0x80000000, wreg=1, ovf_o=0. SUB 0x80000000-1 also flags overflow.
4. Set-less-than: SLT reg1=0xFFFFFFFF, reg2=1 -> result 1. SLTU with the same operands -> result 0. SLTU 0 vs 0 -> result 0.
5. Stall: load ADDU 3+4 (wd=7), then hold stall_i=1 for 2 cycles -> ex_wdata_o stays 7 throughout; mem_wreg_o=0 during the stall. After release, exactly one cycle has mem_wreg_o=1, mem_wdata_o=7.
6. Flush and reset: flush_i with an OR in S -> next cycle ex_wreg_o=0 and mem_wreg_o=0. rst asserted during a stall -> every output is 0 / NOPRegAddr on the following edge.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the St.PU five-stage pipeline.
//
// Latches the decoded operation into an ID/EX register, evaluates the
// logic / shift / arithmetic result combinationally, forwards it back to
// decode on the ex_* bus and registers it into EX/MEM for the memory stage.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   stall_i, flush_i   hold / kill the instruction currently in EX
//   aluop_i, alusel_i  operation code and result class from decode
//   reg1_i, reg2_i     operands
//   wd_i, wreg_i       destination address and write enable
//   ex_wreg_o/ex_wd_o/ex_wdata_o     combinational forwarding bus
//   mem_wreg_o/mem_wd_o/mem_wdata_o  EX/MEM register
//   ovf_o              EX/MEM register: signed overflow of previous EX op
//
// Pipeline control (the only handshake this stage has):
//   priority is rst > flush_i > stall_i > load. flush_i clears ID/EX and
//   EX/MEM. stall_i holds ID/EX and pushes a bubble into EX/MEM, so a held
//   instruction reaches MEM exactly once, on the first edge with stall_i=0.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic        ex_wreg_o,
  output logic [4:0]  ex_wd_o,
  output logic [31:0] ex_wdata_o,
  output logic        mem_wreg_o,
  output logic [4:0]  mem_wd_o,
  output logic [31:0] mem_wdata_o,
  output logic        ovf_o
);

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;

  // ID/EX register
  logic [7:0]  s_aluop;
  logic [2:0]  s_alusel;
  logic [31:0] s_reg1;
  logic [31:0] s_reg2;
  logic [4:0]  s_wd;
  logic        s_wreg;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      s_aluop  <= EXE_NOP_OP;
      s_alusel <= EXE_RES_NOP;
      s_reg1   <= ZERO_WORD;
      s_reg2   <= ZERO_WORD;
      s_wd     <= NOP_REG_ADDR;
      s_wreg   <= 1'b0;
    end else if (!stall_i) begin
      s_aluop  <= aluop_i;
      s_alusel <= alusel_i;
      s_reg1   <= reg1_i;
      s_reg2   <= reg2_i;
      s_wd     <= wd_i;
      s_wreg   <= wreg_i;
    end
  end

  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] result;
  logic        ovf;

  assign sum  = s_reg1 + s_reg2;
  assign diff = s_reg1 - s_reg2;

  always_comb begin
    result = ZERO_WORD;
    ovf    = 1'b0;
    unique case (s_alusel)
      EXE_RES_LOGIC: begin
        case (s_aluop)
          EXE_OR_OP:  result = s_reg1 | s_reg2;
          EXE_AND_OP: result = s_reg1 & s_reg2;
          EXE_XOR_OP: result = s_reg1 ^ s_reg2;
          EXE_NOR_OP: result = ~(s_reg1 | s_reg2);
          default:    result = ZERO_WORD;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (s_aluop)
          EXE_SLL_OP: result = s_reg2 << s_reg1[4:0];
          EXE_SRL_OP: result = s_reg2 >> s_reg1[4:0];
          EXE_SRA_OP: result = $unsigned($signed(s_reg2) >>> s_reg1[4:0]);
          default:    result = ZERO_WORD;
        endcase
      end
      EXE_RES_ARITHMETIC: begin
        case (s_aluop)
          EXE_ADD_OP: begin
            result = sum;
            // same-sign operands whose sum flips sign
            ovf = (s_reg1[31] == s_reg2[31]) && (sum[31] != s_reg1[31]);
          end
          EXE_ADDU_OP: result = sum;
          EXE_SUB_OP: begin
            result = diff;
            // opposite-sign operands whose difference takes reg2's sign
            ovf = (s_reg1[31] != s_reg2[31]) && (diff[31] != s_reg1[31]);
          end
          EXE_SUBU_OP: result = diff;
          EXE_SLT_OP:  result = {31'd0, $signed(s_reg1) < $signed(s_reg2)};
          EXE_SLTU_OP: result = {31'd0, s_reg1 < s_reg2};
          default:     result = ZERO_WORD;
        endcase
      end
      default: result = ZERO_WORD;
    endcase
  end

  assign ex_wd_o    = s_wd;
  assign ex_wdata_o = result;
  assign ex_wreg_o  = s_wreg & ~ovf;

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (rst || flush_i || stall_i) begin
      mem_wreg_o  <= 1'b0;
      mem_wd_o    <= NOP_REG_ADDR;
      mem_wdata_o <= ZERO_WORD;
      ovf_o       <= 1'b0;
    end else begin
      mem_wreg_o  <= ex_wreg_o;
      mem_wd_o    <= ex_wd_o;
      mem_wdata_o <= ex_wdata_o;
      ovf_o       <= ovf;
    end
  end

endmodule
